extreme_seq: RTL and testbench

//  Sequential min/max finder built around the shared 2-bit magnitude comparator and select-mux.

---
 rtl/ext_seq_pkg.sv | 14 +
 rtl/extreme_seq_if.sv | 27 ++
 rtl/extreme_seq_cmp_sel_unit.sv | 26 ++
 rtl/extreme_seq.sv | 118 +++++++++++
 tb/tb_extreme_seq.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/ext_seq_pkg.sv
// Shared types and constants for the sequential min/max finder.
package ext_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FIRST   = 2'd1,
        S_COLLECT = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic MODE_MIN = 1'b0;
    localparam logic MODE_MAX = 1'b1;

endpackage

// File: rtl/extreme_seq_if.sv
// Sample-in / result-out handshake bundle for extreme_seq.
interface extreme_seq_if #(
    parameter int WIDTH   = 2,
    parameter int COUNT_W = 4
);
    logic               start;
    logic               mode;
    logic [COUNT_W-1:0] len;
    logic               in_valid;
    logic [WIDTH-1:0]   in_data;
    logic               in_ready;
    logic               busy;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [COUNT_W-1:0] out_index;
    logic               out_ack;

    modport master (
        output start, mode, len, in_valid, in_data, out_ack,
        input  in_ready, busy, out_valid, out_data, out_index
    );

    modport slave (
        input  start, mode, len, in_valid, in_data, out_ack,
        output in_ready, busy, out_valid, out_data, out_index
    );
endinterface

// File: rtl/extreme_seq_cmp_sel_unit.sv
// Parallel less-than / greater-than compare with a mode-driven select.
module cmp_sel_unit
    import ext_seq_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic             hit
);
    logic cmp_lt;
    logic cmp_gt;

    assign cmp_lt = (a < b);
    assign cmp_gt = (a > b);

    always_comb begin
        hit = 1'b0;
        unique case (sel)
            MODE_MIN: hit = cmp_lt;
            MODE_MAX: hit = cmp_gt;
            default:  hit = 1'b0;
        endcase
    end
endmodule

// File: rtl/extreme_seq.sv
// Sequential min/max finder: one sample per cycle against a running best,
// result held until acknowledged.
module extreme_seq
    import ext_seq_pkg::*;
#(
    parameter int WIDTH   = 2,
    parameter int COUNT_W = 4
) (
    input  logic          clk,
    input  logic          rst,
    extreme_seq_if.slave  bus
);
    state_t             state_q, state_d;
    logic [WIDTH-1:0]   best_q, best_d;
    logic [COUNT_W-1:0] best_idx_q, best_idx_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [COUNT_W-1:0] len_q, len_d;
    logic               mode_q, mode_d;
    logic               in_ready;
    logic               hit;
    logic               last_sample;

    cmp_sel_unit #(.WIDTH(WIDTH)) u_cmp (
        .a   (bus.in_data),
        .b   (best_q),
        .sel (mode_q),
        .hit (hit)
    );

    assign last_sample = (count_q == len_q - COUNT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (bus.start && (bus.len != '0)) state_d = S_FIRST;
            S_FIRST:   if (bus.in_valid) state_d = (len_q == COUNT_W'(1)) ? S_DONE : S_COLLECT;
            S_COLLECT: if (bus.in_valid && last_sample) state_d = S_DONE;
            S_DONE:    if (bus.out_ack) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Result ports are gated by state so they read zero outside DONE and
    // drop immediately on an asynchronous reset.
    always_comb begin
        in_ready      = 1'b0;
        bus.busy      = (state_q != S_IDLE);
        bus.out_valid = 1'b0;
        bus.out_data  = '0;
        bus.out_index = '0;
        unique case (state_q)
            S_FIRST, S_COLLECT: in_ready = 1'b1;
            S_DONE: begin
                bus.out_valid = 1'b1;
                bus.out_data  = best_q;
                bus.out_index = best_idx_q;
            end
            default: ;
        endcase
    end

    assign bus.in_ready = in_ready;

    always_comb begin
        best_d     = best_q;
        best_idx_d = best_idx_q;
        count_d    = count_q;
        len_d      = len_q;
        mode_d     = mode_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start && (bus.len != '0)) begin
                    mode_d  = bus.mode;
                    len_d   = bus.len;
                    count_d = '0;
                end
            end
            S_FIRST: begin
                if (bus.in_valid) begin
                    best_d     = bus.in_data;
                    best_idx_d = '0;
                    count_d    = COUNT_W'(1);
                end
            end
            S_COLLECT: begin
                if (bus.in_valid) begin
                    if (hit) begin
                        best_d     = bus.in_data;
                        best_idx_d = count_q;
                    end
                    count_d = count_q + COUNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best_q     <= '0;
            best_idx_q <= '0;
            count_q    <= '0;
            len_q      <= '0;
            mode_q     <= MODE_MIN;
        end else begin
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
            count_q    <= count_d;
            len_q      <= len_d;
            mode_q     <= mode_d;
        end
    end
endmodule

// File: tb/tb_extreme_seq.sv
// Directed bench for extreme_seq with a sequence-level reference model.
module tb_extreme_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    extreme_seq_if #(.WIDTH(2), .COUNT_W(4)) bus ();

    extreme_seq #(.WIDTH(2), .COUNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference: phase 0 = idle, 1 = taking samples, 2 = holding result.
    int phase = 0;
    int m_len = 0;
    bit m_mode = 1'b0;
    int q[$];

    function automatic void extreme(input bit mx, output int v, output int ix);
        v  = q[0];
        ix = 0;
        for (int i = 1; i < q.size(); i++) begin
            if (mx ? (q[i] > v) : (q[i] < v)) begin
                v  = q[i];
                ix = i;
            end
        end
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            phase = 0;
            q.delete();
        end else begin
            case (phase)
                0: if (bus.start && bus.len != 0) begin
                       m_mode = bus.mode;
                       m_len  = int'(bus.len);
                       q.delete();
                       phase  = 1;
                   end
                1: if (bus.in_valid) begin
                       q.push_back(int'(bus.in_data));
                       if (q.size() == m_len) phase = 2;
                   end
                default: if (bus.out_ack) phase = 0;
            endcase
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        int ev, ei;
        ev = 0;
        ei = 0;
        if (phase == 2) extreme(m_mode, ev, ei);
        chk("busy",      int'(bus.busy),      int'(phase != 0));
        chk("in_ready",  int'(bus.in_ready),  int'(phase == 1));
        chk("out_valid", int'(bus.out_valid), int'(phase == 2));
        chk("out_data",  int'(bus.out_data),  ev);
        chk("out_index", int'(bus.out_index), ei);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_start(input bit m, input int l);
        bus.start = 1'b1;
        bus.mode  = m;
        bus.len   = 4'(l);
        step();
        bus.start = 1'b0;
    endtask

    task automatic send(input int d);
        bus.in_valid = 1'b1;
        bus.in_data  = 2'(d);
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic result(input string name, input int d, input int ix);
        chk({name, "_valid"}, int'(bus.out_valid), 1);
        chk({name, "_data"},  int'(bus.out_data),  d);
        chk({name, "_index"}, int'(bus.out_index), ix);
    endtask

    task automatic ack();
        bus.out_ack = 1'b1;
        step();
        bus.out_ack = 1'b0;
        chk("ack_idle", int'(bus.busy), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0; bus.mode = 1'b0; bus.len = '0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ack = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_busy",  int'(bus.busy),      0);
        chk("rst_valid", int'(bus.out_valid), 0);
        chk("rst_ready", int'(bus.in_ready),  0);
        step();

        // max, tie keeps first occurrence
        do_start(1'b1, 4);
        send(1); send(3); send(2); send(3);
        result("t1", 3, 1);
        ack();

        // min, result held without ack
        do_start(1'b0, 5);
        send(2); send(1); send(3); send(0); send(0);
        for (int i = 0; i < 5; i++) result("t2_hold", 0, 3);
        for (int i = 0; i < 4; i++) step();
        ack();
        chk("t2_valid_drop", int'(bus.out_valid), 0);

        // single-sample sequence and zero length
        do_start(1'b1, 1);
        send(2);
        result("t3", 2, 0);
        ack();
        do_start(1'b1, 0);
        chk("t3_len0_busy", int'(bus.busy), 0);
        step();
        chk("t3_len0_busy2", int'(bus.busy), 0);

        // in_valid gaps stall the sequence
        do_start(1'b1, 3);
        send(0);
        bus.in_data = 2'd3; step();
        bus.in_data = 2'd2; step();
        send(3);
        bus.in_data = 2'd3; step();
        send(1);
        result("t4", 3, 1);
        ack();

        // asynchronous reset mid-sequence
        do_start(1'b1, 4);
        send(1); send(2);
        #2 rst = 1'b1;
        #1;
        chk("t5_busy",  int'(bus.busy),      0);
        chk("t5_ready", int'(bus.in_ready),  0);
        chk("t5_valid", int'(bus.out_valid), 0);
        chk("t5_data",  int'(bus.out_data),  0);
        step();
        rst = 1'b0;
        step();
        do_start(1'b1, 2);
        send(1); send(2);
        result("t5", 2, 1);
        ack();

        // mid-sequence start/mode/len changes ignored
        do_start(1'b1, 4);
        send(1);
        bus.start = 1'b1; bus.mode = 1'b0; bus.len = 4'd2;
        send(2);
        bus.start = 1'b0;
        send(0); send(3);
        result("t6", 3, 3);
        bus.in_valid = 1'b1; bus.in_data = 2'd1;
        step();
        chk("t6_done_ready", int'(bus.in_ready), 0);
        step();
        bus.in_valid = 1'b0;
        result("t6_hold", 3, 3);
        // start with ack in DONE: ack wins, no new sequence
        bus.start = 1'b1; bus.mode = 1'b1; bus.len = 4'd2;
        ack();
        bus.start = 1'b0;
        step();
        chk("t6_no_restart", int'(bus.busy), 0);
        do_start(1'b1, 2);
        send(2); send(1);
        result("t6b", 2, 0);
        ack();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
